// File: rtl/f2d_conv_arbiter.sv
// rtl/f2d_conv_arbiter.sv - round-robin arbiter sharing one float->double converter among NUM_REQ requesters
// Optional watchdog on the converter handshake: define F2D_ARB_WATCHDOG_EN.
module f2d_conv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_a,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [63:0]            rsp_z,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   cvt_en,
    output logic                   cvt_rst,
    output logic [31:0]            cvt_a,
    input  logic [63:0]            cvt_z,
    input  logic                   cvt_complete
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    cvt_a_q, cvt_a_d;
    logic [63:0]    rsp_z_q, rsp_z_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           first_q, first_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand_idx;
    logic           take_result;
    logic           wd_expired;

    // Search starts one past the last winner so every requester is reached within NUM_REQ grants.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_idx = IDW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!gnt_found && req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // The converter may still show complete from the previous job during the first WAIT cycle.
    assign take_result = (state_q == S_WAIT) && !first_q && cvt_complete;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        cvt_a_d  = cvt_a_q;
        rsp_z_d  = rsp_z_q;
        rsp_id_d = rsp_id_q;
        first_d  = first_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    cvt_a_d  = req_a[32*gnt_idx +: 32];
                    id_d     = gnt_idx;
                    rr_ptr_d = gnt_idx;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                first_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                first_d = 1'b0;
                if (take_result) begin
                    rsp_z_d  = cvt_z;
                    rsp_id_d = id_q;
                    state_d  = S_RESP;
                end else if (wd_expired) begin
                    rsp_z_d  = 64'h7FF8_0000_0000_0000;
                    rsp_id_d = id_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= IDW'(NUM_REQ - 1);
            id_q     <= '0;
            cvt_a_q  <= '0;
            rsp_z_q  <= '0;
            rsp_id_q <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            cvt_a_q  <= cvt_a_d;
            rsp_z_q  <= rsp_z_d;
            rsp_id_q <= rsp_id_d;
            first_q  <= first_d;
        end
    end

`ifdef F2D_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_q, wd_d;
    logic           rsp_err_q, rsp_err_d;

    assign wd_expired = (state_q == S_WAIT) && (wd_q == WDW'(TIMEOUT - 1));

    always_comb begin
        wd_d      = wd_q;
        rsp_err_d = rsp_err_q;
        if (state_q == S_ISSUE) begin
            wd_d = '0;
        end else if (state_q == S_WAIT) begin
            wd_d = wd_q + 1'b1;
            if (take_result) begin
                rsp_err_d = 1'b0;
            end else if (wd_expired) begin
                rsp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign wd_expired     = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    assign req_ready = (state_q == S_IDLE && gnt_found && !rst) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign busy      = (state_q != S_IDLE);
    assign cvt_en    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign cvt_rst   = (state_q == S_ISSUE);
    assign cvt_a     = cvt_a_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_z     = rsp_z_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_f2d_conv_arbiter.sv
// tb/tb_f2d_conv_arbiter.sv - self-checking bench for f2d_conv_arbiter with a behavioural converter
module tb_f2d_conv_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 16;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_z;
    logic         rsp_err;
    logic         busy;
    logic         cvt_en;
    logic         cvt_rst;
    logic [31:0]  cvt_a;
    logic [63:0]  cvt_z;
    logic         cvt_complete;

    logic         stuck;
    logic         stale;
    logic [63:0]  m_z;
    int           m_cnt;
    logic         m_run;
    logic         m_done;

    int checks = 0;
    int errors = 0;

    f2d_conv_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_z        (rsp_z),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .cvt_en       (cvt_en),
        .cvt_rst      (cvt_rst),
        .cvt_a        (cvt_a),
        .cvt_z        (cvt_z),
        .cvt_complete (cvt_complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dn_shifts(input logic [31:0] a);
        logic [23:0] t;
        int k;
        k = 0;
        if (a[30:23] == 8'h00 && a[22:0] != 23'h0) begin
            t = {1'b0, a[22:0]};
            while (!t[23]) begin
                t = t << 1;
                k++;
            end
        end
        return k;
    endfunction

    function automatic logic [63:0] f2d(input logic [31:0] a);
        logic [23:0] t;
        int k;
        if (a[30:23] == 8'hFF) return {a[31], 11'h7FF, a[22:0], 29'b0};
        if (a[30:0] == 31'h0) return {a[31], 63'b0};
        if (a[30:23] == 8'h00) begin
            k = dn_shifts(a);
            t = {1'b0, a[22:0]} << k;
            return {a[31], 11'(897 - k), t[22:0], 29'b0};
        end
        return {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0};
    endfunction

    // Converter: loads on en&rst, completes 3 cycles later plus one per denormal shift, clears when en drops.
    always @(posedge clk) begin
        if (!cvt_en) begin
            m_run  <= 1'b0;
            m_done <= 1'b0;
        end else if (cvt_rst) begin
            m_run  <= 1'b1;
            m_done <= 1'b0;
            m_cnt  <= 3 + dn_shifts(cvt_a);
            m_z    <= f2d(cvt_a);
        end else if (m_run) begin
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_run  <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    assign cvt_z        = m_z;
    assign cvt_complete = !stuck && (m_done || stale);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_lanes(input logic [31:0] a, input int id);
        for (int i = 0; i < NREQ; i++)
            req_a[32*i +: 32] = (i == id) ? a : (32'h7FC0_0000 | 32'(i));
    endtask

    task automatic do_txn(input string name, input logic [3:0] vmask, input logic [31:0] a,
                          input int exp_id, input logic [63:0] exp_z, input int exp_lat,
                          input logic exp_err, input bit inj_stale);
        int n;
        int lat;
        logic got;
        logic issue_ok;
        @(negedge clk);
        drive_lanes(a, exp_id);
        req_valid = vmask;
        #1;
        n = 0;
        while (req_ready == 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " grant"}, 64'(req_ready), 64'(4'b0001 << exp_id));
        @(posedge clk);
        #1;
        req_valid = 4'b0;
        lat = 0;
        got = 1'b0;
        issue_ok = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) issue_ok = cvt_en && cvt_rst && busy && (cvt_a == a);
            if (inj_stale) stale = (lat == 2);
            got = rsp_valid;
        end
        stale = 1'b0;
        chk({name, " issue"}, 64'(issue_ok), 64'(1));
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " rsp_z"}, rsp_z, exp_z);
        chk({name, " rsp_id/err"}, 64'({rsp_id, rsp_err}), 64'({2'(exp_id), exp_err}));
        @(negedge clk);
        chk({name, " post"}, 64'({rsp_valid, busy, cvt_en}), 64'(0));
        chk({name, " hold"}, rsp_z, exp_z);
    endtask

    typedef struct {
        logic [3:0]  vmask;
        logic [31:0] a;
        int          exp_id;
        logic [63:0] exp_z;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vecs[0]  = '{4'hF, 32'h3F80_0000, 0, 64'h3FF0_0000_0000_0000, 6};
        vecs[1]  = '{4'hF, 32'hC000_0000, 1, 64'hC000_0000_0000_0000, 6};
        vecs[2]  = '{4'hF, 32'hC000_0000, 2, 64'hC000_0000_0000_0000, 6};
        vecs[3]  = '{4'hF, 32'hC000_0000, 3, 64'hC000_0000_0000_0000, 6};
        vecs[4]  = '{4'hF, 32'hC000_0000, 0, 64'hC000_0000_0000_0000, 6};
        vecs[5]  = '{4'h9, 32'h0000_0001, 3, 64'h36A0_0000_0000_0000, 29};
        vecs[6]  = '{4'h9, 32'h7F80_0000, 0, 64'h7FF0_0000_0000_0000, 6};
        vecs[7]  = '{4'h6, 32'h0000_0000, 1, 64'h0000_0000_0000_0000, 6};
        vecs[8]  = '{4'h4, 32'h8000_0000, 2, 64'h8000_0000_0000_0000, 6};
        vecs[9]  = '{4'h3, 32'h4049_0FDB, 0, 64'h4009_21FB_6000_0000, 6};
        vecs[10] = '{4'h1, 32'h3F80_0000, 0, 64'h3FF0_0000_0000_0000, 6};

        rst = 1'b1;
        req_valid = 4'hF;
        req_a = '0;
        stuck = 1'b0;
        stale = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ready", 64'(req_ready), 64'(0));
        chk("reset ctl", 64'({busy, cvt_en, cvt_rst, rsp_valid, rsp_err}), 64'(0));
        chk("reset data", 64'({rsp_z == 64'h0, rsp_id, cvt_a}), 64'({1'b1, 2'b00, 32'h0}));
        rst = 1'b0;
        req_valid = 4'h0;

        for (int v = 0; v < 11; v++)
            do_txn($sformatf("vec%0d", v), vecs[v].vmask, vecs[v].a, vecs[v].exp_id,
                   vecs[v].exp_z, vecs[v].exp_lat, 1'b0, 1'b0);

        do_txn("stale", 4'h1, 32'h3F80_0000, 0, 64'h3FF0_0000_0000_0000, 6, 1'b0, 1'b1);

        @(negedge clk);
        drive_lanes(32'h3F80_0000, 2);
        req_valid = 4'b0100;
        #1;
        chk("rstwait grant", 64'(req_ready), 64'(4'b0100));
        @(posedge clk);
        #1;
        req_valid = 4'b0;
        repeat (3) @(negedge clk);
        chk("rstwait in wait", 64'({busy, cvt_en, cvt_rst}), 64'(3'b110));
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait ctl", 64'({busy, cvt_en, rsp_valid}), 64'(0));
        chk("rstwait rsp_z", rsp_z, 64'h0);
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("rstwait no rsp", 64'(n), 64'(0));
        do_txn("rst_after", 4'b0101, 32'h4000_0000, 0, 64'h4000_0000_0000_0000, 6, 1'b0, 1'b0);

        stuck = 1'b1;
`ifdef F2D_ARB_WATCHDOG_EN
        do_txn("watchdog", 4'b0010, 32'h3F80_0000, 1, 64'h7FF8_0000_0000_0000, TO + 2, 1'b1, 1'b0);
        stuck = 1'b0;
        do_txn("wd_recover", 4'b0100, 32'h3F80_0000, 2, 64'h3FF0_0000_0000_0000, 6, 1'b0, 1'b0);
`else
        @(negedge clk);
        drive_lanes(32'h3F80_0000, 1);
        req_valid = 4'b0010;
        #1;
        chk("stuck grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clk);
        #1;
        req_valid = 4'b0;
        n = 0;
        repeat (3 * TO) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("stuck no rsp", 64'({n != 0, busy, cvt_en, rsp_err}), 64'(4'b0110));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stuck = 1'b0;
        do_txn("stuck_recover", 4'b0110, 32'h3F80_0000, 1, 64'h3FF0_0000_0000_0000, 6, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
